mw_add_seq: RTL and testbench

- Word-serial multi-precision adder that sits directly downstream of the operand feeder and drives the combinational rca stage.
- Accepts an N-word operand pair one word per beat, least-significant word (LSW) first.
- Chains the carry between beats through a register and emits one registered sum word per beat.
- Final beat carries the operation's carry-out and signed-overflow flags to the consumer.

---
 rtl/add_pkg.sv | 17 +
 rtl/rca.sv | 25 ++
 rtl/mw_add_seq.sv | 101 ++++++++++
 tb/tb_mw_add_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared types and defaults for the word-serial multi-precision adder and its rca stage.
package add_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int BIT_WIDTH_DEF = 8;
  localparam int NUM_WORDS_DEF = 4;

  // Beat counter width; kept at least one bit so the counter always exists.
  function automatic int cnt_width(input int num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

endpackage

// File: rtl/rca.sv
// Combinational ripple-carry adder for one word: s + carry_out = a + b + carry_in.
module rca
  import add_pkg::*;
#(
  parameter int bit_width = BIT_WIDTH_DEF
) (
  input  logic [bit_width-1:0] a,
  input  logic [bit_width-1:0] b,
  input  logic                 carry_in,
  output logic [bit_width-1:0] s,
  output logic                 carry_out
);

  logic [bit_width:0] c;

  assign c[0] = carry_in;

  for (genvar i = 0; i < bit_width; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign carry_out = c[bit_width];

endmodule

// File: rtl/mw_add_seq.sv
// Word-serial multi-precision adder: one operand word pair per beat, LSW first,
// carry chained between beats, one registered sum word out per beat.
//
// state | meaning
// IDLE  | next accepted beat is the first word of an operation (uses cin)
// RUN   | mid-operation; next accepted beat uses the chained carry
module mw_add_seq
  import add_pkg::*;
#(
  parameter int bit_width = BIT_WIDTH_DEF,
  parameter int num_words = NUM_WORDS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [bit_width-1:0] in_a,
  input  logic [bit_width-1:0] in_b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [bit_width-1:0] out_s,
  output logic                 out_last,
  output logic                 out_carry,
  output logic                 out_ovf
);

  localparam int CNT_W = cnt_width(num_words);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(num_words - 1);

  state_e               state_q;
  logic [CNT_W-1:0]     beat_cnt_q;
  logic                 carry_q;
  logic                 out_valid_q;
  logic [bit_width-1:0] out_s_q;
  logic                 out_last_q;
  logic                 out_carry_q;
  logic                 out_ovf_q;

  logic                 accept;
  logic                 is_last;
  logic                 rca_cin;
  logic [bit_width-1:0] rca_s;
  logic                 rca_cout;
  logic                 ovf_d;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // A first beat never closes an operation since num_words >= 2.
  assign is_last  = (state_q == RUN) && (beat_cnt_q == LAST_CNT);
  assign rca_cin  = (state_q == IDLE) ? cin : carry_q;
  assign ovf_d    = (in_a[bit_width-1] == in_b[bit_width-1]) &&
                    (rca_s[bit_width-1] != in_a[bit_width-1]);

  rca #(.bit_width(bit_width)) u_rca (
    .a         (in_a),
    .b         (in_b),
    .carry_in  (rca_cin),
    .s         (rca_s),
    .carry_out (rca_cout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_s_q     <= '0;
      out_last_q  <= 1'b0;
      out_carry_q <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_s_q     <= rca_s;
      carry_q     <= rca_cout;
      if (is_last) begin
        out_last_q  <= 1'b1;
        out_carry_q <= rca_cout;
        out_ovf_q   <= ovf_d;
        beat_cnt_q  <= '0;
        state_q     <= IDLE;
      end else begin
        out_last_q  <= 1'b0;
        out_carry_q <= 1'b0;
        out_ovf_q   <= 1'b0;
        beat_cnt_q  <= beat_cnt_q + 1'b1;
        state_q     <= RUN;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;
  assign out_last  = out_last_q;
  assign out_carry = out_carry_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mw_add_seq.sv
// Self-checking bench for mw_add_seq (8-bit words, 2 words per operation).
module tb_mw_add_seq;

  localparam int BW = 8;
  localparam int NW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_a = '0;
  logic [BW-1:0] in_b = '0;
  logic          cin = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [BW-1:0] out_s;
  logic          out_last;
  logic          out_carry;
  logic          out_ovf;

  mw_add_seq #(.bit_width(BW), .num_words(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_last  (out_last),
    .out_carry (out_carry),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  typedef struct packed {
    logic [7:0] s;
    logic       last;
    logic       carry;
    logic       ovf;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    gap_en   = 1'b0;
  bit    rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beats for one operation given its full-width sum and flags.
  task automatic push_op(input logic [15:0] s, input logic c, input logic o);
    for (int w = 0; w < NW; w++) begin
      beat_t e;
      e.s     = s[w*8 +: 8];
      e.last  = (w == NW - 1);
      e.carry = (w == NW - 1) ? c : 1'b0;
      e.ovf   = (w == NW - 1) ? o : 1'b0;
      exp_q.push_back(e);
    end
  endtask

  // Reference: plain 16-bit arithmetic, overflow from the signed range.
  task automatic model_op(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [31:0] u;
    int          sa;
    int          sb;
    int          ss;
    u  = 32'(a) + 32'(b) + 32'(c);
    sa = $signed(a);
    sb = $signed(b);
    ss = sa + sb + int'(c);
    push_op(u[15:0], u[16], (ss > 32767) || (ss < -32768));
  endtask

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic c);
    int t;
    if (gap_en) begin
      int g;
      g = $urandom_range(0, 2);
      if (g != 0) begin
        in_valid = 1'b0;
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    cin      = c;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      t++;
      if (t > 200) begin
        chk("accept_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
  endtask

  // Upper-word cin is inverted on purpose: it must be ignored after the first beat.
  task automatic send_op(input logic [15:0] a, input logic [15:0] b, input logic c);
    send_beat(a[7:0], b[7:0], c);
    send_beat(a[15:8], b[15:8], ~c);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {21'd0, out_s, out_last, out_carry, out_ovf}, 32'd0);
        if (n_fail == 0) n_fail++;
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat", {21'd0, out_s, out_last, out_carry, out_ovf}, {21'd0, e});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  vec_t tbl[7];

  initial begin
    tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[4] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    tbl[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[6] = '{16'h0102, 16'h0304, 1'b0, 16'h0406, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_s",     32'(out_s),     32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_out_carry", 32'(out_carry), 32'd0);
    chk("rst_out_ovf",   32'(out_ovf),   32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed table, back-to-back operations with no idle cycles between them.
    for (int i = 0; i < 7; i++) begin
      push_op(tbl[i].s, tbl[i].c, tbl[i].o);
      send_op(tbl[i].a, tbl[i].b, tbl[i].cin);
    end
    idle(4);
    chk("table_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure after the first word.
    out_ready = 1'b0;
    push_op(16'h0100, 1'b0, 1'b0);
    fork
      send_op(16'h00FF, 16'h0001, 1'b0);
      begin
        int t;
        t = 0;
        while (!out_valid && t < 50) begin
          @(negedge clk);
          t++;
        end
        repeat (4) begin
          @(negedge clk);
          chk("bp_in_ready",  32'(in_ready),  32'd0);
          chk("bp_out_valid", 32'(out_valid), 32'd1);
          chk("bp_out_s",     32'(out_s),     32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(4);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of an operation while its first word is held.
    out_ready = 1'b0;
    send_beat(8'hFF, 8'h01, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_out_s",     32'(out_s),     32'd0);
    chk("mid_out_last",  32'(out_last),  32'd0);
    chk("mid_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    push_op(16'h0406, 1'b0, 1'b0);
    send_op(16'h0102, 16'h0304, 1'b0);
    idle(4);
    chk("mid_drained", 32'(exp_q.size()), 32'd0);

    // Randomized operations with input gaps and random consumer stalls.
    gap_en   = 1'b1;
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      logic        c;
      case ($urandom_range(0, 4))
        0:       a = 16'hFFFF;
        1:       a = 16'h7FFF;
        default: a = 16'($urandom);
      endcase
      b = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      c = 1'($urandom);
      model_op(a, b, c);
      send_op(a, b, c);
    end
    in_valid = 1'b0;
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    begin
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
        @(posedge clk);
        t++;
      end
    end
    @(negedge clk);
    chk("final_drained", 32'(exp_q.size()), 32'd0);
    chk("final_idle",    32'(out_valid),    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
